// File: rtl/urish_spell.sv
// urish_spell: SPELL 8-bit stack CPU (32-byte memory, 8-entry stack) driven
// and debugged through a bit-serial register-access port.
module urish_spell (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [1:0] {FETCH, EXECUTE, DELAY} state_t;
  state_t      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic [2:0]  sp_q, sp_d, sp_m1, sp_m2;
  logic [7:0]  sh_q, sh_d, ir_q, ir_d, top, sec, rd;
  logic [15:0] cnt_q, cnt_d;
  logic        stop_q, stop_d, sleep_q, sleep_d, run_p_q, step_p_q;
  logic [7:0]  stk_q [8];
  logic [7:0]  stk_d [8];
  logic [7:0]  mem_q [32];
  logic        mem_we, run, step, load, dump, step_rise, rise, go, unused;
  logic [1:0]  sel;
  assign {sel, dump, load, step, run} = {ui_in[6:5], ui_in[3], ui_in[2], ui_in[1], ui_in[0]};
  assign unused = &{1'b0, ena, uio_in, ui_in[7]};
  assign uio_out = '0;
  assign uio_oe = '0;
  assign uo_out = {4'b0, sh_q[0], state_q == DELAY, stop_q, sleep_q};
  assign sp_m1 = sp_q - 3'd1;
  assign sp_m2 = sp_q - 3'd2;
  assign top = stk_q[sp_m1];
  assign sec = stk_q[sp_m2];
  assign step_rise = step & ~step_p_q;
  assign rise = (run & ~run_p_q) | step_rise;
  // a run/step edge releases stop/sleep in the same cycle it starts the fetch
  assign go = (run | step_rise) & (rise | ~(stop_q | sleep_q));
  assign rd = sel == 2'd0 ? {3'b0, pc_q} : sel == 2'd1 ? {5'b0, sp_q} : sel == 2'd2 ? ir_q : top;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    sp_d = sp_q;
    sh_d = sh_q;
    ir_d = ir_q;
    cnt_d = cnt_q;
    stop_d = stop_q & ~rise;
    sleep_d = sleep_q & ~rise;
    stk_d = stk_q;
    mem_we = 1'b0;
    case (state_q)
      FETCH:
        if (go) begin
          ir_d = mem_q[pc_q];
          pc_d = pc_q + 5'd1;
          state_d = EXECUTE;
        end else if (load) begin
          if (sel == 2'd0) pc_d = sh_q[4:0];
          if (sel == 2'd1) sp_d = sh_q[2:0];
          if (sel == 2'd2) begin
            ir_d = sh_q;
            state_d = EXECUTE;
          end
          if (sel == 2'd3) stk_d[sp_m1] = sh_q;
        end else sh_d = dump ? rd : {ui_in[4], sh_q[7:1]};
      EXECUTE: begin
        state_d = FETCH;
        case (ir_q)
          8'h2B, 8'h2D, 8'h26, 8'h7C, 8'h5E: begin
            sp_d = sp_m1;
            stk_d[sp_m2] = ir_q == 8'h2B ? sec + top : ir_q == 8'h2D ? sec - top :
                           ir_q == 8'h26 ? sec & top : ir_q == 8'h7C ? sec | top : sec ^ top;
          end
          8'h3E: stk_d[sp_m1] = top >> 1;
          8'h3C: stk_d[sp_m1] = top << 1;
          8'h7E: stk_d[sp_m1] = ~top;
          8'h64: begin
            stk_d[sp_q] = top;
            sp_d = sp_q + 3'd1;
          end
          8'h78: begin
            stk_d[sp_m1] = sec;
            stk_d[sp_m2] = top;
          end
          8'h70: sp_d = sp_m1;
          8'h40: stk_d[sp_m1] = mem_q[top[4:0]];
          8'h21: begin
            mem_we = 1'b1;
            sp_d = sp_m2;
          end
          8'h3D: begin
            pc_d = top[4:0];
            sp_d = sp_m1;
          end
          8'h3F: begin
            pc_d = sec != 8'd0 ? top[4:0] : pc_q;
            sp_d = sp_m2;
          end
          8'h3B: stop_d = 1'b1;
          8'h7A: sleep_d = 1'b1;
          8'h2C: begin
            sp_d = sp_m1;
            state_d = top != 8'd0 ? DELAY : FETCH;
            cnt_d = {top, 8'h00} - 16'd1;
          end
          default: begin
            stk_d[sp_q] = ir_q;
            sp_d = sp_q + 3'd1;
          end
        endcase
      end
      DELAY: begin
        state_d = cnt_q == 16'd0 ? FETCH : DELAY;
        cnt_d = cnt_q - 16'd1;
      end
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= '0;
      sp_q <= '0;
      sh_q <= '0;
      ir_q <= '0;
      cnt_q <= '0;
      stop_q <= 1'b0;
      sleep_q <= 1'b0;
      run_p_q <= 1'b0;
      step_p_q <= 1'b0;
      for (int i = 0; i < 8; i++) stk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      sp_q <= sp_d;
      sh_q <= sh_d;
      ir_q <= ir_d;
      cnt_q <= cnt_d;
      stop_q <= stop_d;
      sleep_q <= sleep_d;
      run_p_q <= run;
      step_p_q <= step;
      stk_q <= stk_d;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[top[4:0]] <= sec;
  end
endmodule

// File: tb/tb_urish_spell.sv
// tb_urish_spell: directed and random checks of SPELL against an
// instruction-level push/pop model held in the bench.
module tb_urish_spell;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int n_chk = 0;
  int n_fail = 0;
  int wait_cnt = 0;
  bit chk_on = 1'b0;
  logic [7:0] m_mem [32];
  logic [7:0] m_stk [8];
  logic [2:0] m_sp = '0;
  logic [4:0] m_pc = '0;
  logic [7:0] m_sh = '0;
  logic m_stop = 1'b0, m_sleep = 1'b0, m_wait = 1'b0;
  logic [7:0] ops [16] = '{"+", "-", "&", "|", "^", ">", "<", "~", "d", "x", "p", "@", "=", "?", ";", "z"};
  logic [7:0] v, e;

  always #5 clk = ~clk;

  urish_spell dut (.clk(clk), .rst(rst), .ena(1'b1), .ui_in(ui_in), .uo_out(uo_out),
                   .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("uo_out", 32'(uo_out), 32'({4'b0, m_sh[0], m_wait, m_stop, m_sleep}));
      check("uio_out_oe", 32'({uio_out, uio_oe}), 32'd0);
    end
    if (uo_out[2]) wait_cnt++;
  end

  function automatic void push(input logic [7:0] x);
    m_stk[m_sp] = x;
    m_sp++;
  endfunction

  function automatic logic [7:0] pop();
    m_sp--;
    return m_stk[m_sp];
  endfunction

  function automatic int model_exec(input logic [7:0] op);
    logic [7:0] a, b;
    int n = 0;
    case (op)
      "+": begin b = pop(); a = pop(); push(a + b); end
      "-": begin b = pop(); a = pop(); push(a - b); end
      "&": begin b = pop(); a = pop(); push(a & b); end
      "|": begin b = pop(); a = pop(); push(a | b); end
      "^": begin b = pop(); a = pop(); push(a ^ b); end
      ">": begin b = pop(); push(b >> 1); end
      "<": begin b = pop(); push(b << 1); end
      "~": begin b = pop(); push(~b); end
      "d": begin b = pop(); push(b); push(b); end
      "x": begin b = pop(); a = pop(); push(b); push(a); end
      "p": b = pop();
      "@": begin b = pop(); push(m_mem[b[4:0]]); end
      "!": begin b = pop(); a = pop(); m_mem[b[4:0]] = a; end
      "=": begin b = pop(); m_pc = b[4:0]; end
      "?": begin b = pop(); a = pop(); if (a != 8'd0) m_pc = b[4:0]; end
      ";": m_stop = 1'b1;
      "z": m_sleep = 1'b1;
      ",": begin b = pop(); n = int'(b) * 256; end
      default: push(op);
    endcase
    return n;
  endfunction

  function automatic logic [7:0] rand_op();
    return $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 31)) : ops[$urandom_range(0, 15)];
  endfunction

  task automatic tick(input logic [7:0] ui);
    ui_in = ui;
    @(posedge clk);
    #1;
  endtask

  task automatic do_delay(input int n, input logic [7:0] ui);
    if (n > 0) m_wait = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick(ui);
      if (i == n - 1) m_wait = 1'b0;
    end
  endtask

  task automatic shift(input logic b);
    tick({3'b0, b, 4'b0});
    m_sh = {b, m_sh[7:1]};
  endtask

  task automatic shift_byte(input logic [7:0] x);
    for (int i = 0; i < 8; i++) shift(x[i]);
  endtask

  task automatic load(input logic [1:0] sel);
    int n;
    tick({1'b0, sel, 5'b00100});
    if (sel == 2'd0) m_pc = m_sh[4:0];
    else if (sel == 2'd1) m_sp = m_sh[2:0];
    else if (sel == 2'd3) m_stk[m_sp - 3'd1] = m_sh;
    else begin
      tick(8'h00);
      n = model_exec(m_sh);
      do_delay(n, 8'h00);
    end
  endtask

  task automatic read_reg(input logic [1:0] sel, output logic [7:0] r);
    tick({1'b0, sel, 5'b01000});
    m_sh = sel == 2'd0 ? {3'b0, m_pc} : sel == 2'd1 ? {5'b0, m_sp} : m_stk[m_sp - 3'd1];
    for (int i = 0; i < 8; i++) begin
      r[i] = uo_out[3];
      shift(1'b0);
    end
  endtask

  task automatic exec(input logic [7:0] op);
    shift_byte(op);
    load(2'd2);
  endtask

  task automatic store(input logic [4:0] a, input logic [7:0] x);
    exec(8'h00);
    shift_byte(x);
    load(2'd3);
    exec(8'h00);
    shift_byte({3'b0, a});
    load(2'd3);
    exec("!");
  endtask

  task automatic step_one();
    logic [7:0] op;
    int n;
    tick(8'h02);
    m_stop = 1'b0;
    m_sleep = 1'b0;
    op = m_mem[m_pc];
    m_pc++;
    tick(8'h00);
    n = model_exec(op);
    do_delay(n, 8'h00);
  endtask

  task automatic run_prog(input int max_instr);
    logic [7:0] op;
    int n;
    for (int k = 0; k < max_instr; k++) begin
      tick(8'h01);
      if (k == 0) begin
        m_stop = 1'b0;
        m_sleep = 1'b0;
      end
      op = m_mem[m_pc];
      m_pc++;
      tick(8'h01);
      n = model_exec(op);
      do_delay(n, 8'h01);
      if (m_stop || m_sleep) break;
    end
  endtask

  task automatic fill_mem();
    for (int a = 0; a < 32; a++) store(5'(a), rand_op());
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_stk[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 check("reset_uo_out", 32'(uo_out), 32'h00);
    rst = 1'b0;
    chk_on = 1'b1;
    read_reg(2'd0, v);
    check("reset_pc_dump", 32'(v), 32'h00);
    shift_byte(8'h2A);
    load(2'd0);
    read_reg(2'd0, v);
    check("pc_load_5bit", 32'(v), 32'h0A);
    shift_byte(8'h15);
    tick(8'h0C);
    m_pc = m_sh[4:0];
    read_reg(2'd0, v);
    check("load_beats_dump", 32'(v), 32'h15);
    fill_mem();
    shift_byte(8'h00);
    load(2'd1);
    exec("5");
    exec("3");
    exec("+");
    read_reg(2'd3, v);
    check("exec_add_top", 32'(v), 32'h68);
    read_reg(2'd1, v);
    check("exec_add_sp", 32'(v), 32'h01);
    store(5'd0, ";");
    shift_byte(8'h00);
    load(2'd0);
    step_one();
    check("step_stop_flag", 32'(uo_out[1]), 32'h1);
    read_reg(2'd0, v);
    check("step_pc", 32'(v), 32'h01);
    store(5'd0, 8'h02);
    store(5'd1, ",");
    store(5'd2, ";");
    shift_byte(8'h00);
    load(2'd0);
    wait_cnt = 0;
    run_prog(8);
    check("delay_cycles", 32'(wait_cnt), 32'd512);
    check("delay_then_stop", 32'(uo_out[1]), 32'h1);
    read_reg(2'd0, v);
    check("delay_pc", 32'(v), 32'h03);
    shift_byte(8'h00);
    load(2'd1);
    for (int i = 0; i < 9; i++) exec(8'h10 + 8'(i));
    read_reg(2'd1, v);
    check("wrap_sp", 32'(v), 32'h01);
    read_reg(2'd3, v);
    check("wrap_top", 32'(v), 32'h18);
    for (int it = 0; it < 8; it++) begin
      fill_mem();
      shift_byte(8'($urandom_range(0, 31)));
      load(2'd0);
      if ($urandom_range(0, 1) != 0) run_prog(30);
      else repeat (6) step_one();
      repeat (4) exec(rand_op());
      e = {3'b0, m_pc};
      read_reg(2'd0, v);
      check("rand_pc", 32'(v), 32'(e));
      e = {5'b0, m_sp};
      read_reg(2'd1, v);
      check("rand_sp", 32'(v), 32'(e));
      e = m_stk[m_sp - 3'd1];
      read_reg(2'd3, v);
      check("rand_top", 32'(v), 32'(e));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
